fixed_subframe_decoder: RTL and testbench
=========================================

FIXED_SUBFRAME_DECODER -- requirements
Module: fixed_subframe_decoder

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16: width of samples, residuals and RAM words (8..24).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: width of RAM read address.
REQ-003 SHALL have parameter BLOCK_WIDTH, default 16: width of block-size count.
REQ-004 iClock  in  1  single clock; all state on rising edge.
REQ-005 iReset  in  1  asynchronous, active-low reset.
REQ-006 iEnable  in  1  start/run; low freezes FSM.
REQ-007 iBaseAddr  in  ADDR_WIDTH  RAM address of subframe header word.
REQ-008 iBlockSize  in  BLOCK_WIDTH  samples per subframe; sampled at start.
REQ-009 iData  in  SAMPLE_WIDTH  RAM read data, valid one cycle after oReadAddr.
REQ-010 oReadAddr  out  ADDR_WIDTH  RAM read address.
REQ-011 oSample  out  SAMPLE_WIDTH  signed decoded sample.
REQ-012 oSampleValid  out  1  oSample valid; held until accepted.
REQ-013 iSampleReady  in  1  consumer accepts sample when high with oSampleValid.
REQ-014 oFrameDone  out  1  one-cycle pulse after last sample accepted.
REQ-015 oError  out  1  sticky error flag.

Function
REQ-016 Header word bits[3:0] SHALL select type: 0 CONSTANT, 1 VERBATIM, 8+k FIXED order k (k=0..4); all other codes are invalid.
REQ-017 Words following header SHALL be, in address order: CONSTANT one value; VERBATIM iBlockSize samples; FIXED k warm-up samples then iBlockSize-k residuals, one per word.
REQ-018 FSM states SHALL be IDLE, HDR, FETCH, LATCH, EMIT, DONE, ERROR.
REQ-019 IDLE->HDR when iEnable=1; latch iBlockSize, drive oReadAddr=iBaseAddr.
REQ-020 HDR: decode header on iData; invalid type or iBlockSize=0 -> ERROR; else -> FETCH with address+1.
REQ-021 FETCH drives oReadAddr; LATCH computes and registers oSample, sets oSampleValid -> EMIT; minimum three cycles per sample with iSampleReady held high.
REQ-022 EMIT: on iSampleReady=1 clear oSampleValid; if samples emitted == block size -> DONE, else -> FETCH (CONSTANT: -> LATCH reusing held value, no further reads).
REQ-023 oSample and oSampleValid SHALL stay stable while iSampleReady=0; no reads advance during stall.
REQ-024 DONE SHALL pulse oFrameDone for one cycle then -> IDLE; a new frame starts only if iEnable=1 in IDLE.
REQ-025 FIXED predictor on history s1..s4 (most recent first): order0 r; order1 r+s1; order2 r+2s1-s2; order3 r+3s1-3s2+s3; order4 r+4s1-6s2+4s3-s4.
REQ-026 Predictor arithmetic SHALL be signed at SAMPLE_WIDTH+4 bits; result truncated to SAMPLE_WIDTH (two's-complement wrap).
REQ-027 Warm-up samples SHALL be emitted unchanged and loaded into history; history shifts on each emitted sample.
REQ-028 If iBlockSize < order k, only iBlockSize warm-up samples SHALL be emitted, no residuals read.
REQ-029 iEnable=0 outside IDLE SHALL freeze state, address, counters and outputs; resuming continues exactly.
REQ-030 ERROR SHALL set oError, hold oSampleValid=0, remain until reset.
REQ-031 oReadAddr SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-032 Asserting iReset (low) at any time, including mid-frame, SHALL immediately force IDLE, oSampleValid=0, oFrameDone=0, oError=0, oSample=0, oReadAddr=0, history and counters 0.

Structure
REQ-033 Shared package fixed_subframe_pkg SHALL hold type codes, FSM state encoding and MAX_ORDER=4.
REQ-034 Predictor arithmetic and history SHALL be sub-module fixed_predictor (history register, order input, residual in, sample out).

Verification
REQ-035 CONSTANT, value 0x1234, block 8, ready high -> eight samples 0x1234, exactly two RAM reads, one oFrameDone pulse.
REQ-036 VERBATIM block 4, words 5,-3,7,0 -> samples 5,-3,7,0 in order, then oFrameDone.
REQ-037 FIXED order2, warm-up 10,12, residuals 0,1,-2 -> samples 10,12,14,17,18.
REQ-038 FIXED order1, iSampleReady low for 5 cycles at sample 2 -> oSample stable, oReadAddr unchanged, output sequence unchanged.
REQ-039 Header code 5 -> oError=1, no oSampleValid; iReset low mid-FIXED-frame -> all outputs 0 asynchronously, clean restart.
REQ-040 SAMPLE_WIDTH=24, FIXED order4 with residuals driving overflow -> output equals reference model truncated to 24 bits.

Source files
------------

// File: rtl/fixed_subframe_pkg.sv
// Shared definitions for the fixed-subframe decoder: header type codes,
// FSM state encoding, subframe kinds and the header decode helper.
package fixed_subframe_pkg;

  localparam int MAX_ORDER = 4;

  localparam logic [3:0] CODE_CONSTANT   = 4'd0;
  localparam logic [3:0] CODE_VERBATIM   = 4'd1;
  localparam logic [3:0] CODE_FIXED_BASE = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_LATCH,
    ST_EMIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    KIND_CONSTANT,
    KIND_VERBATIM,
    KIND_FIXED
  } kind_t;

  typedef struct packed {
    logic       valid;
    kind_t      kind;
    logic [2:0] order;
  } header_t;

  // Map the 4-bit header type code onto a subframe kind and predictor order.
  function automatic header_t decode_header(input logic [3:0] code);
    header_t h;
    h.valid = 1'b0;
    h.kind  = KIND_VERBATIM;
    h.order = 3'd0;
    if (code == CODE_CONSTANT) begin
      h.valid = 1'b1;
      h.kind  = KIND_CONSTANT;
    end else if (code == CODE_VERBATIM) begin
      h.valid = 1'b1;
    end else if (code >= CODE_FIXED_BASE && code <= CODE_FIXED_BASE + 4'(MAX_ORDER)) begin
      h.valid = 1'b1;
      h.kind  = KIND_FIXED;
      h.order = 3'(code - CODE_FIXED_BASE);
    end
    return h;
  endfunction

endpackage

// File: rtl/fixed_predictor.sv
// Fixed linear predictor: keeps the last MAX_ORDER decoded samples and adds
// the order-selected polynomial prediction to the incoming residual.
// Order 0 passes the residual straight through (warm-up, verbatim, constant).
module fixed_predictor
  import fixed_subframe_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_shift,
  input  logic [2:0]              i_order,
  input  logic [SAMPLE_WIDTH-1:0] i_residual,
  output logic [SAMPLE_WIDTH-1:0] o_sample
);

  // Four guard bits hold the worst-case order-4 sum without overflow.
  localparam int EW = SAMPLE_WIDTH + 4;

  logic [SAMPLE_WIDTH-1:0] r_hist [MAX_ORDER];
  logic signed [EW-1:0]    w_r, w_s1, w_s2, w_s3, w_s4, w_pred, w_sum;

  function automatic logic signed [EW-1:0] sext(input logic [SAMPLE_WIDTH-1:0] v);
    return {{4{v[SAMPLE_WIDTH-1]}}, v};
  endfunction

  assign w_r  = sext(i_residual);
  assign w_s1 = sext(r_hist[0]);
  assign w_s2 = sext(r_hist[1]);
  assign w_s3 = sext(r_hist[2]);
  assign w_s4 = sext(r_hist[3]);

  // Polynomial prediction selected by order, then wrapped back to sample width.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_pred = '0;
    unique case (i_order)
      3'd1: w_pred = w_s1;
      3'd2: w_pred = (w_s1 <<< 1) - w_s2;
      3'd3: w_pred = (w_s1 <<< 1) + w_s1 - ((w_s2 <<< 1) + w_s2) + w_s3;
      3'd4: w_pred = (w_s1 <<< 2) - ((w_s2 <<< 2) + (w_s2 <<< 1)) + (w_s3 <<< 2) - w_s4;
      default: w_pred = '0;
    endcase
    w_sum    = w_r + w_pred;
    o_sample = w_sum[SAMPLE_WIDTH-1:0];
  end

  // History shift register, most recent sample at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the history is only four words of flops, so it is reset explicitly;
      // a true RAM would not be reset this way.
      for (int i = 0; i < MAX_ORDER; i++) r_hist[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < MAX_ORDER; i++) r_hist[i] <= '0;
    end else if (i_shift) begin
      r_hist[0] <= o_sample;
      for (int i = 1; i < MAX_ORDER; i++) r_hist[i] <= r_hist[i-1];
    end
  end

endmodule

// File: rtl/fixed_subframe_decoder.sv
// Fixed-subframe decoder: reads a header word and the following words from a
// synchronous RAM and emits CONSTANT, VERBATIM or FIXED-predicted samples
// through a valid/ready handshake. iEnable low freezes everything except IDLE.
module fixed_subframe_decoder
  import fixed_subframe_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int BLOCK_WIDTH  = 16
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iEnable,
  input  logic [ADDR_WIDTH-1:0]   iBaseAddr,
  input  logic [BLOCK_WIDTH-1:0]  iBlockSize,
  input  logic [SAMPLE_WIDTH-1:0] iData,
  output logic [ADDR_WIDTH-1:0]   oReadAddr,
  output logic [SAMPLE_WIDTH-1:0] oSample,
  output logic                    oSampleValid,
  input  logic                    iSampleReady,
  output logic                    oFrameDone,
  output logic                    oError
);

  state_t                  r_state;
  kind_t                   r_kind;
  logic [2:0]              r_order;
  logic [BLOCK_WIDTH-1:0]  r_block;
  logic [BLOCK_WIDTH-1:0]  r_count;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [SAMPLE_WIDTH-1:0] r_sample;
  logic                    r_valid;
  logic                    r_done;
  logic                    r_error;
  logic                    r_hdr_wait;

  header_t                 w_hdr;
  logic                    w_warmup;
  logic                    w_last;
  logic                    w_hold_const;
  logic [2:0]              w_pred_order;
  logic [SAMPLE_WIDTH-1:0] w_pred_sample;

  assign w_hdr        = decode_header(iData[3:0]);
  assign w_warmup     = (r_kind == KIND_FIXED) && (r_count < BLOCK_WIDTH'(r_order));
  assign w_pred_order = (r_kind == KIND_FIXED && !w_warmup) ? r_order : 3'd0;
  assign w_last       = (r_count + BLOCK_WIDTH'(1)) == r_block;
  // CONSTANT frames read their value once and re-emit the held sample.
  assign w_hold_const = (r_kind == KIND_CONSTANT) && (r_count != '0);

  fixed_predictor #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_predictor (
    .clk        (iClock),
    .rst_n      (iReset),
    .i_clear    (iEnable && r_state == ST_IDLE),
    .i_shift    (iEnable && r_state == ST_LATCH),
    .i_order    (w_pred_order),
    .i_residual (iData),
    .o_sample   (w_pred_sample)
  );

  // Decoder FSM with registered address and handshake outputs.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state    <= ST_IDLE;
      r_kind     <= KIND_VERBATIM;
      r_order    <= 3'd0;
      r_block    <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_hdr_wait <= 1'b0;
    end else if (iEnable) begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // sees the values from before this clock edge.
      unique case (r_state)
        ST_IDLE: begin
          r_block    <= iBlockSize;
          r_addr     <= iBaseAddr;
          r_count    <= '0;
          r_hdr_wait <= 1'b0;
          r_state    <= ST_HDR;
        end
        ST_HDR: begin
          // The RAM returns the header one cycle after its address is presented.
          if (!r_hdr_wait) begin
            r_hdr_wait <= 1'b1;
          end else begin
            r_hdr_wait <= 1'b0;
            if (!w_hdr.valid || r_block == '0) begin
              r_error <= 1'b1;
              r_state <= ST_ERROR;
            end else begin
              r_kind  <= w_hdr.kind;
              r_order <= w_hdr.order;
              r_addr  <= r_addr + ADDR_WIDTH'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: r_state <= ST_LATCH;
        ST_LATCH: begin
          if (!w_hold_const) r_sample <= w_pred_sample;
          r_valid <= 1'b1;
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (iSampleReady) begin
            r_valid <= 1'b0;
            r_count <= r_count + BLOCK_WIDTH'(1);
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else if (r_kind == KIND_CONSTANT) begin
              r_state <= ST_LATCH;
            end else begin
              r_addr  <= r_addr + ADDR_WIDTH'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_ERROR: begin
          r_error <= 1'b1;
          r_valid <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oReadAddr    = r_addr;
  assign oSample      = r_sample;
  assign oSampleValid = r_valid;
  assign oFrameDone   = r_done;
  assign oError       = r_error;

endmodule

// File: tb/tb_fixed_subframe_decoder.sv
// Self-checking bench: a 16-bit and a 24-bit decoder run in lockstep from one
// shared word memory; decoded samples are compared with a plain-arithmetic
// reference model evaluated at each sample width.
module tb_fixed_subframe_decoder;

  typedef logic [23:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        iReset, iEnable, iSampleReady;
  logic [15:0] iBaseAddr, iBlockSize;
  logic [15:0] d16, a16, s16, a24;
  logic [23:0] d24, s24;
  logic        v16, v24, f16, f24, e16, e24;

  logic [23:0] mem [0:65535];

  int      checks = 0;
  int      errors = 0;
  word_q_t fw, got16, got24;
  int      done_cnt;
  bit      addr_seen [logic [15:0]];

  always #5 clk = ~clk;

  // Synchronous RAM: data appears one cycle after the address.
  always @(posedge clk) begin
    d16 <= mem[a16][15:0];
    d24 <= mem[a24];
  end

  fixed_subframe_decoder #(.SAMPLE_WIDTH(16)) u_dut16 (
    .iClock(clk), .iReset(iReset), .iEnable(iEnable), .iBaseAddr(iBaseAddr),
    .iBlockSize(iBlockSize), .iData(d16), .oReadAddr(a16), .oSample(s16),
    .oSampleValid(v16), .iSampleReady(iSampleReady), .oFrameDone(f16), .oError(e16)
  );

  fixed_subframe_decoder #(.SAMPLE_WIDTH(24)) u_dut24 (
    .iClock(clk), .iReset(iReset), .iEnable(iEnable), .iBaseAddr(iBaseAddr),
    .iBlockSize(iBlockSize), .iData(d24), .oReadAddr(a24), .oSample(s24),
    .oSampleValid(v24), .iSampleReady(iSampleReady), .oFrameDone(f24), .oError(e24)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed value of the low W bits of x.
  function automatic longint wrapw(input longint x, input int W);
    longint m, v;
    m = longint'(1) << W;
    v = x & (m - 1);
    if (v >= (m >>> 1)) v = v - m;
    return v;
  endfunction

  // Reference decode of the frame in fw (header first) at sample width W.
  function automatic word_q_t model(input int W, input int n);
    word_q_t     q;
    longint      h [4];
    longint      r, v;
    int          code, k;
    logic [23:0] m;
    m    = (W == 24) ? 24'hFFFFFF : 24'h00FFFF;
    code = int'(fw[0][3:0]);
    k    = code - 8;
    for (int j = 0; j < 4; j++) h[j] = 0;
    for (int i = 0; i < n; i++) begin
      if (code == 0) begin
        v = wrapw(longint'(fw[1]), W);
      end else begin
        r = wrapw(longint'(fw[1+i]), W);
        if (code == 1 || i < k) v = r;
        else begin
          case (k)
            0:       v = r;
            1:       v = r + h[0];
            2:       v = r + 2*h[0] - h[1];
            3:       v = r + 3*h[0] - 3*h[1] + h[2];
            default: v = r + 4*h[0] - 6*h[1] + 4*h[2] - h[3];
          endcase
          v = wrapw(v, W);
        end
      end
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = v;
      q.push_back(24'(v) & m);
    end
    return q;
  endfunction

  task automatic new_frame(input int code);
    logic [19:0] up;
    up = 20'($urandom);
    fw.delete();
    fw.push_back({up, 4'(code)});
  endtask

  task automatic load_frame(input logic [15:0] base);
    for (int i = 0; i < fw.size(); i++) mem[base + 16'(i)] = fw[i];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " addr16"}, a16, 0);  check({tag, " addr24"}, a24, 0);
    check({tag, " smp16"}, s16, 0);   check({tag, " smp24"}, s24, 0);
    check({tag, " vld16"}, v16, 0);   check({tag, " vld24"}, v24, 0);
    check({tag, " done16"}, f16, 0);  check({tag, " done24"}, f24, 0);
    check({tag, " err16"}, e16, 0);   check({tag, " err24"}, e24, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    iReset = 1'b0; iEnable = 1'b0; iSampleReady = 1'b1;
    repeat (2) @(negedge clk);
    iReset = 1'b1;
  endtask

  // Runs one frame to its done pulse, with an optional 5-cycle ready stall at
  // sample stall_at and an optional 4-cycle enable freeze at cycle freeze_at.
  task automatic run_frame(input logic [15:0] base, input int n,
                           input int stall_at, input int freeze_at);
    int          acc = 0, stall_left = 0, freeze_left = 0;
    bit          ended = 0, saw_done = 0, stalled = 0;
    logic [15:0] h_s16, h_a16;
    logic [23:0] h_s24;
    logic        h_v16;
    got16.delete(); got24.delete(); addr_seen.delete(); done_cnt = 0;
    @(negedge clk);
    iBaseAddr = base; iBlockSize = 16'(n); iEnable = 1'b1; iSampleReady = 1'b1;
    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      @(negedge clk);
      addr_seen[a16] = 1'b1;
      if (f16) done_cnt++;
      if (saw_done) begin
        iEnable = 1'b0;
        ended   = 1;
      end else begin
        if (f16) saw_done = 1;
        if (freeze_left > 0) begin
          check("freeze addr16", a16, h_a16);
          check("freeze smp16", s16, h_s16);
          check("freeze smp24", s24, h_s24);
          check("freeze vld16", v16, h_v16);
          freeze_left--;
          if (freeze_left == 0) iEnable = 1'b1;
        end else if (cyc == freeze_at && !f16) begin
          iEnable = 1'b0;
          h_a16 = a16; h_s16 = s16; h_s24 = s24; h_v16 = v16;
          freeze_left = 4;
        end
        if (stall_left > 0) begin
          check("stall smp16", s16, h_s16);
          check("stall addr16", a16, h_a16);
          check("stall vld16", v16, 1);
          stall_left--;
          iSampleReady = (stall_left == 0);
        end else if (stall_at >= 0 && acc == stall_at && v16 && !stalled) begin
          stalled = 1;
          iSampleReady = 1'b0;
          h_s16 = s16; h_a16 = a16;
          stall_left = 5;
        end
        if (v16 && iSampleReady && iEnable) begin
          got16.push_back(24'(s16));
          acc++;
        end
        if (v24 && iSampleReady && iEnable) got24.push_back(s24);
      end
    end
    check("frame finished in budget", 64'(ended), 1);
    iEnable = 1'b0;
  endtask

  task automatic compare_frame(input string name, input int n);
    word_q_t e16, e24;
    logic [63:0] o;
    e16 = model(16, n);
    e24 = model(24, n);
    check({name, " count16"}, got16.size(), e16.size());
    check({name, " count24"}, got24.size(), e24.size());
    for (int i = 0; i < e16.size(); i++) begin
      o = (i < got16.size()) ? 64'(got16[i]) : 64'hDEAD;
      check($sformatf("%s s16[%0d]", name, i), o, 64'(e16[i]));
      o = (i < got24.size()) ? 64'(got24[i]) : 64'hDEAD;
      check($sformatf("%s s24[%0d]", name, i), o, 64'(e24[i]));
    end
    check({name, " done pulses"}, done_cnt, 1);
  endtask

  task automatic run_error(input string name, input logic [15:0] base, input int n);
    bit seen_valid = 0;
    @(negedge clk);
    iBaseAddr = base; iBlockSize = 16'(n); iEnable = 1'b1; iSampleReady = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (v16 || v24) seen_valid = 1;
    end
    check({name, " err16"}, e16, 1);
    check({name, " err24"}, e24, 1);
    check({name, " no valid"}, 64'(seen_valid), 0);
    iEnable = 1'b0;
    repeat (3) @(negedge clk);
    check({name, " err sticky"}, e16, 1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int          ref37 [5];
    int          code, n, nw;
    logic [15:0] base;
    ref37 = '{10, 12, 14, 17, 18};

    for (int i = 0; i < 65536; i++) mem[i] = '0;
    iReset = 1'b0; iEnable = 1'b0; iSampleReady = 1'b1;
    iBaseAddr = '0; iBlockSize = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    iReset = 1'b1;

    // CONSTANT 0x1234, block 8: two reads, eight identical samples.
    new_frame(0); fw.push_back(24'h001234);
    load_frame(16'h0100);
    run_frame(16'h0100, 8, -1, -1);
    compare_frame("constant", 8);
    check("constant first sample", (got16.size() > 0) ? 64'(got16[0]) : 64'hDEAD, 64'h1234);
    check("constant distinct reads", addr_seen.num(), 2);

    // VERBATIM 5,-3,7,0.
    new_frame(1);
    fw.push_back(24'd5); fw.push_back(24'hFFFFFD); fw.push_back(24'd7); fw.push_back(24'd0);
    load_frame(16'h0200);
    run_frame(16'h0200, 4, -1, -1);
    compare_frame("verbatim", 4);
    check("verbatim s16[1] is -3", (got16.size() > 1) ? 64'(got16[1]) : 64'hDEAD, 64'hFFFD);

    // FIXED order 2: warm-up 10,12, residuals 0,1,-2 -> 10,12,14,17,18.
    new_frame(10);
    fw.push_back(24'd10); fw.push_back(24'd12); fw.push_back(24'd0);
    fw.push_back(24'd1);  fw.push_back(24'hFFFFFE);
    load_frame(16'h0300);
    run_frame(16'h0300, 5, -1, -1);
    compare_frame("fixed2", 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("fixed2 literal[%0d]", i),
            (i < got24.size()) ? 64'(got24[i]) : 64'hDEAD, 64'(ref37[i]));

    // FIXED order 1 with a 5-cycle ready stall at sample 2.
    new_frame(9);
    for (int i = 0; i < 6; i++) fw.push_back(24'($urandom_range(0, 200)) - 24'd100);
    load_frame(16'h0400);
    run_frame(16'h0400, 6, 2, -1);
    compare_frame("fixed1 stall", 6);

    // FIXED order 3 with a block shorter than the order: warm-up only.
    new_frame(11);
    fw.push_back(24'd300); fw.push_back(24'hFFFF00); fw.push_back(24'd77);
    load_frame(16'h0500);
    run_frame(16'h0500, 2, -1, -1);
    compare_frame("fixed3 short", 2);

    // FIXED order 4 with full-range words forcing wrap, address wrapping past 0xFFFF.
    new_frame(12);
    for (int i = 0; i < 12; i++) fw.push_back(24'($urandom));
    load_frame(16'hFFFA);
    run_frame(16'hFFFA, 12, -1, -1);
    compare_frame("fixed4 overflow", 12);

    // Random frames with an enable freeze somewhere inside.
    for (int f = 0; f < 6; f++) begin
      code = $urandom_range(0, 6);
      if (code >= 2) code = code + 6;
      n    = $urandom_range(1, 10);
      nw   = (code == 0) ? 1 : n;
      base = 16'($urandom);
      new_frame(code);
      for (int i = 0; i < nw; i++) fw.push_back(24'($urandom));
      load_frame(base);
      run_frame(base, n, -1, $urandom_range(2, 20));
      compare_frame($sformatf("random%0d code%0d", f, code), n);
    end

    // Invalid header code 5 -> sticky error, no samples.
    new_frame(5); fw.push_back(24'd1);
    load_frame(16'h0600);
    run_error("bad code", 16'h0600, 4);
    do_reset();
    check("err cleared by reset", e16, 0);

    // Valid header with block size 0 -> error.
    new_frame(1); fw.push_back(24'd1);
    load_frame(16'h0700);
    run_error("block zero", 16'h0700, 0);
    do_reset();

    // Asynchronous reset in the middle of a FIXED frame, then a clean restart.
    new_frame(9);
    for (int i = 0; i < 10; i++) fw.push_back(24'($urandom_range(0, 1000)));
    load_frame(16'h0800);
    @(negedge clk);
    iBaseAddr = 16'h0800; iBlockSize = 16'd10; iEnable = 1'b1; iSampleReady = 1'b1;
    repeat (12) @(negedge clk);
    check("pre-reset addr busy", 64'(a16 != 16'h0000), 1);
    #2 iReset = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    iEnable = 1'b0;
    iReset  = 1'b1;
    run_frame(16'h0800, 10, -1, -1);
    compare_frame("restart", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
